branch_seq_ctrl: RTL and testbench
==================================

Name: branch_seq_ctrl

Overview:
Sequencer for conditional-branch resolution in the ARM core. It accepts one branch request at a time from decode. It waits until the ALU flags are no longer pending, evaluates the 4-bit condition against flags [Z,C,N,V], and computes the branch target. On a taken branch it drives the PC load and holds the front-end flush for a fixed number of cycles. It sits between decode, the ALU flag register and the fetch PC.

Parameters:
ADDR_W, 32, PC and target width
OFF_W, 8, signed halfword branch offset width
PC_AHEAD, 4, pipeline PC offset added to the request PC
FLUSH_CYCLES, 2, cycles flush is held on a taken branch (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  branch request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_cond  in  4  condition code (0000 EQ ... 1101 LE, 1110 AL, 1111 undefined)
req_pc  in  ADDR_W  address of the branch instruction
req_offset  in  OFF_W  signed offset in halfwords
flags  in  4  [Z,C,N,V] from the ALU flag register
flags_pending  in  1  a flag-setting instruction is still in flight
abort  in  1  cancel the current branch (exception/interrupt)
pc_load  out  1  one-cycle pulse: fetch loads pc_target
pc_target  out  ADDR_W  branch target, valid while pc_load=1
flush  out  1  front-end flush
done  out  1  one-cycle completion pulse
taken  out  1  qualifies done: 1 = branch taken
undef  out  1  qualifies done: cond was 1111
busy  out  1  state != IDLE

Behaviour:
- Reset is async, active-high. After reset: state IDLE; pc_load, flush, done, taken, undef, busy = 0; pc_target = 0; req_ready = 1.
- req_ready = (state==IDLE) && !abort. This is the only combinational output. All other outputs are registered.
- States are IDLE, WAIT, EVAL, FLUSH.
- IDLE:
  - On handshake, latch cond, pc and offset.
  - Next state is WAIT if flags_pending=1, otherwise EVAL.
- WAIT:
  - Hold while flags_pending=1.
  - Move to EVAL in the cycle after flags_pending is seen 0.
- EVAL: flags are sampled this cycle and the condition is evaluated combinationally.
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1.
  - 1111 evaluates false.
  - If true: next state FLUSH, with pc_load=1, flush=1 and an internal counter = FLUSH_CYCLES-1.
  - If false: next state IDLE, with done=1, taken=0, and undef=1 when cond==1111.
- Target arithmetic: pc_target = req_pc + PC_AHEAD + (sign_extend(req_offset) << 1), modulo 2^ADDR_W. Wrap-around is silent. pc_target is registered at the EVAL edge.
- FLUSH:
  - flush=1 every cycle; pc_load=1 only in the first FLUSH cycle.
  - The counter decrements each cycle.
  - When the counter is 0, the next state is IDLE with done=1 and taken=1; flush drops to 0 in that same cycle.
- Latency with no pending flags (handshake in cycle N):
  - Not taken: done in N+2, req_ready=1 in N+2.
  - Taken: pc_load in N+2, flush in N+2..N+1+FLUSH_CYCLES, done/taken in N+2+FLUSH_CYCLES, req_ready=1 in that same cycle.
- Abort:
  - In any non-IDLE state, abort returns to IDLE on the next edge.
  - pc_load and flush are 0 from that cycle; no done pulse.
  - In IDLE, abort blocks acceptance via req_ready.
  - Abort has priority over every other transition, including the EVAL and FLUSH completions.
- done, taken and undef are single-cycle pulses. taken and undef are 0 whenever done=0.
- A new request may be accepted in the same cycle that done pulses.
- A flags_pending change during EVAL or FLUSH is ignored; flags are sampled only in EVAL.

Decomposition:
- Package branch_pkg:
  - cond_e enum for the 16 codes.
  - Flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_V=0.
  - state_e {IDLE, WAIT, EVAL, FLUSH}.
- Sub-module cond_eval: purely combinational (cond, flags) -> ok, shared with other condition users. The FSM, counter and target adder stay in branch_seq_ctrl.

Test Plan:
- BEQ, flags=1000, pc=0x100, offset=0x10, no pending -> N+2: pc_load=1, pc_target=0x124, flush=1; flush high N+2..N+3; N+4: done=1, taken=1, req_ready=1.
- BNE, flags=1000, offset=0xFE -> N+2: done=1, taken=0, pc_load=0, flush never asserted.
- BGT, flags_pending high for 3 cycles after acceptance, then flags=0000, pc=0x200, offset=0xFE -> busy throughout the wait; pc_load two cycles after pending drops, pc_target=0x200.
- Cond 1111, any flags -> done=1, taken=0, undef=1, no flush. Separately, AL with pc=0xFFFFFFFC, offset=0x01 -> pc_target=0x00000002 (wrap).
- abort asserted in the first FLUSH cycle -> next cycle flush=0, pc_load=0, no done, req_ready=1. rst asserted mid-WAIT -> all outputs 0 immediately, req_ready=1.
- Full sweep of 16 conds × 16 flag values -> taken matches the cond_eval truth table; back-to-back requests accepted in each done cycle.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for conditional-branch resolution: condition codes,
// flag bit positions and sequencer states.
package branch_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_EVAL  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code check against [Z,C,N,V]; the undefined
// code 1111 always evaluates false.
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_ok
);

    logic w_z;
    logic w_c;
    logic w_n;
    logic w_v;

    assign w_z = i_flags[FLAG_Z];
    assign w_c = i_flags[FLAG_C];
    assign w_n = i_flags[FLAG_N];
    assign w_v = i_flags[FLAG_V];

    always_comb begin
        o_ok = 1'b0;
        unique case (cond_e'(i_cond))
            COND_EQ: o_ok = w_z;
            COND_NE: o_ok = !w_z;
            COND_CS: o_ok = w_c;
            COND_CC: o_ok = !w_c;
            COND_MI: o_ok = w_n;
            COND_PL: o_ok = !w_n;
            COND_VS: o_ok = w_v;
            COND_VC: o_ok = !w_v;
            COND_HI: o_ok = w_c && !w_z;
            COND_LS: o_ok = !w_c || w_z;
            COND_GE: o_ok = (w_n == w_v);
            COND_LT: o_ok = (w_n != w_v);
            COND_GT: o_ok = !w_z && (w_n == w_v);
            COND_LE: o_ok = w_z || (w_n != w_v);
            COND_AL: o_ok = 1'b1;
            COND_NV: o_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_seq_ctrl.sv
// Branch resolution sequencer: waits out pending flags, evaluates the
// condition, loads the fetch PC and holds the front-end flush.
module branch_seq_ctrl
    import branch_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int OFF_W        = 8,
    parameter int PC_AHEAD     = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cond,
    input  logic [ADDR_W-1:0] req_pc,
    input  logic [OFF_W-1:0]  req_offset,
    input  logic [3:0]        flags,
    input  logic              flags_pending,
    input  logic              abort,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic              done,
    output logic              taken,
    output logic              undef,
    output logic              busy
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_e              r_state;
    cond_e               r_cond;
    logic [ADDR_W-1:0]   r_pc;
    logic [OFF_W-1:0]    r_off;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_ok;
    logic                w_hs;
    logic [ADDR_W-1:0]   w_off_ext;
    logic [ADDR_W-1:0]   w_target;

    cond_eval u_cond_eval (
        .i_cond  (r_cond),
        .i_flags (flags),
        .o_ok    (w_ok)
    );

    assign req_ready = (r_state == ST_IDLE) && !abort;
    assign w_hs      = req_valid && req_ready;

    // Halfword offset, sign-extended then scaled to bytes; wraps silently.
    assign w_off_ext = {{(ADDR_W-OFF_W){r_off[OFF_W-1]}}, r_off};
    assign w_target  = r_pc + ADDR_W'(PC_AHEAD) + (w_off_ext << 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cond    <= COND_EQ;
            r_pc      <= '0;
            r_off     <= '0;
            r_cnt     <= '0;
            pc_load   <= 1'b0;
            pc_target <= '0;
            flush     <= 1'b0;
            done      <= 1'b0;
            taken     <= 1'b0;
            undef     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            pc_load <= 1'b0;
            done    <= 1'b0;
            taken   <= 1'b0;
            undef   <= 1'b0;
            if (abort && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
                flush   <= 1'b0;
                busy    <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (w_hs) begin
                            r_cond  <= cond_e'(req_cond);
                            r_pc    <= req_pc;
                            r_off   <= req_offset;
                            r_state <= flags_pending ? ST_WAIT : ST_EVAL;
                            busy    <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (!flags_pending) begin
                            r_state <= ST_EVAL;
                        end
                    end
                    ST_EVAL: begin
                        pc_target <= w_target;
                        if (w_ok) begin
                            r_state <= ST_FLUSH;
                            pc_load <= 1'b1;
                            flush   <= 1'b1;
                            r_cnt   <= CNT_W'(FLUSH_CYCLES - 1);
                        end else begin
                            r_state <= ST_IDLE;
                            done    <= 1'b1;
                            undef   <= (r_cond == COND_NV);
                            busy    <= 1'b0;
                        end
                    end
                    ST_FLUSH: begin
                        if (r_cnt == '0) begin
                            r_state <= ST_IDLE;
                            done    <= 1'b1;
                            taken   <= 1'b1;
                            flush   <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Randomized bench for branch_seq_ctrl against a cycle-timeline model
// derived from the condition rules and target arithmetic.
module tb_branch_seq_ctrl;

    localparam int FC = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cond;
    logic [31:0] req_pc;
    logic [7:0]  req_offset;
    logic [3:0]  flags;
    logic        flags_pending;
    logic        abort;
    logic        pc_load;
    logic [31:0] pc_target;
    logic        flush;
    logic        done;
    logic        taken;
    logic        undef;
    logic        busy;

    int checks = 0;
    int errors = 0;

    branch_seq_ctrl #(
        .ADDR_W       (32),
        .OFF_W        (8),
        .PC_AHEAD     (4),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_cond      (req_cond),
        .req_pc        (req_pc),
        .req_offset    (req_offset),
        .flags         (flags),
        .flags_pending (flags_pending),
        .abort         (abort),
        .pc_load       (pc_load),
        .pc_target     (pc_target),
        .flush         (flush),
        .done          (done),
        .taken         (taken),
        .undef         (undef),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit z;
        bit cy;
        bit n;
        bit v;
        z  = f[3];
        cy = f[2];
        n  = f[1];
        v  = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // One full transaction starting in the current cycle; returns in the
    // done cycle so the next call is accepted back-to-back.
    task automatic do_branch(input logic [3:0] c, input logic [3:0] f,
                             input logic [31:0] pc, input logic [7:0] off,
                             input int p, output logic [31:0] tgt_seen);
        bit          exp_t;
        logic [31:0] exp_tgt;
        int          so;
        int          r;
        int          last;
        logic [6:0]  obs;
        logic [6:0]  exp_v;
        exp_t   = ref_cond(c, f);
        so      = int'($signed(off));
        exp_tgt = pc + 32'd4 + 32'(so * 2);
        r       = 2 + p;
        last    = exp_t ? r + FC : r;
        tgt_seen = '0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_at_start got=%b exp=1", req_ready);
        end
        req_valid     = 1'b1;
        req_cond      = c;
        req_pc        = pc;
        req_offset    = off;
        flags_pending = (p > 0);
        flags         = (p > 0) ? 4'($urandom) : f;
        for (int k = 1; k <= last; k++) begin
            step();
            obs   = {pc_load, flush, done, taken, undef, busy, req_ready};
            exp_v = {exp_t && (k == r),
                     exp_t && (k >= r) && (k < r + FC),
                     k == last,
                     (k == last) && exp_t,
                     (k == last) && (c == 4'hF),
                     k < last,
                     k >= last};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL timeline cond=%h flags=%h p=%0d cyc=%0d got{pl,fl,dn,tk,ud,bz,rr}=%b exp=%b",
                         c, f, p, k, obs, exp_v);
            end
            if (exp_t && (k == r)) begin
                tgt_seen = pc_target;
                checks++;
                if (pc_target !== exp_tgt) begin
                    errors++;
                    $display("FAIL pc_target pc=%h off=%h got=%h exp=%h",
                             pc, off, pc_target, exp_tgt);
                end
            end
            if (k < last) begin
                req_valid  = 1'b0;
                req_cond   = 4'($urandom);
                req_pc     = $urandom;
                req_offset = 8'($urandom);
                if (k < p) begin
                    flags_pending = 1'b1;
                    flags         = 4'($urandom);
                end else if (k == p || k == r - 1) begin
                    flags_pending = (k == p) ? 1'b0 : 1'($urandom);
                    flags         = f;
                end else begin
                    flags_pending = 1'($urandom);
                    flags         = 4'($urandom);
                end
            end else begin
                req_valid     = 1'b0;
                flags_pending = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({pc_load, flush, done, taken, undef, busy} !== 6'b0 ||
            pc_target !== 32'h0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got=%b tgt=%h rr=%b exp=0 0 1",
                     {pc_load, flush, done, taken, undef, busy}, pc_target, req_ready);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_directed();
        logic [31:0] t;
        do_branch(4'h0, 4'b1000, 32'h100, 8'h10, 0, t);
        checks++;
        if (t !== 32'h124) begin
            errors++;
            $display("FAIL beq_target got=%h exp=00000124", t);
        end
        do_branch(4'h1, 4'b1000, 32'h180, 8'hFE, 0, t);
        do_branch(4'hC, 4'b0000, 32'h200, 8'hFE, 3, t);
        checks++;
        if (t !== 32'h200) begin
            errors++;
            $display("FAIL bgt_target got=%h exp=00000200", t);
        end
        do_branch(4'hF, 4'($urandom), 32'h300, 8'h04, 0, t);
        do_branch(4'hE, 4'($urandom), 32'hFFFF_FFFC, 8'h01, 0, t);
        checks++;
        if (t !== 32'h0000_0002) begin
            errors++;
            $display("FAIL al_wrap_target got=%h exp=00000002", t);
        end
    endtask

    task automatic test_abort();
        // abort in first FLUSH cycle
        req_valid = 1'b1; req_cond = 4'h0; req_pc = 32'h400;
        req_offset = 8'h08; flags = 4'b1000; flags_pending = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        checks++;
        if ({pc_load, flush} !== 2'b11) begin
            errors++;
            $display("FAIL abort_pre_flush got=%b exp=11", {pc_load, flush});
        end
        abort = 1'b1;
        step();
        checks++;
        if ({pc_load, flush, done, busy, req_ready} !== 5'b0) begin
            errors++;
            $display("FAIL abort_flush got{pl,fl,dn,bz,rr}=%b exp=00000",
                     {pc_load, flush, done, busy, req_ready});
        end
        abort = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready got=%b exp=1", req_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({done, flush, pc_load} !== 3'b0) begin
                errors++;
                $display("FAIL abort_no_done cyc=%0d got=%b exp=000", i,
                         {done, flush, pc_load});
            end
        end
        // abort during EVAL beats a taken evaluation
        req_valid = 1'b1; req_cond = 4'hE;
        step();
        req_valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({pc_load, flush, done, busy} !== 4'b0) begin
            errors++;
            $display("FAIL abort_eval got=%b exp=0000", {pc_load, flush, done, busy});
        end
        // abort in IDLE blocks acceptance
        abort = 1'b1; req_valid = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_ready got=%b exp=0", req_ready);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_accept got=%b exp=0", busy);
        end
        abort = 1'b0; req_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 1'b1; req_cond = 4'h0; req_pc = 32'h500;
        req_offset = 8'h02; flags_pending = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_busy got=%b exp=1", busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pc_load, flush, done, taken, undef, busy} !== 6'b0 ||
            pc_target !== 32'h0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_wait got=%b tgt=%h rr=%b exp=0 0 1",
                     {pc_load, flush, done, taken, undef, busy}, pc_target, req_ready);
        end
        #2 rst = 1'b0;
        flags_pending = 1'b0;
        step();
    endtask

    task automatic test_sweep();
        logic [31:0] t;
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                do_branch(4'(c), 4'(f), $urandom, 8'($urandom), 0, t);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        for (int i = 0; i < 150; i++) begin
            do_branch(4'($urandom), 4'($urandom), $urandom, 8'($urandom),
                      int'($urandom_range(0, 4)), t);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] t;
        for (int i = 0; i < 20; i++) begin
            do_branch(4'($urandom_range(0, 14)), 4'($urandom), $urandom,
                      8'($urandom), 0, t);
        end
        step();
    endtask

    initial begin
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_cond      = 4'h0;
        req_pc        = 32'h0;
        req_offset    = 8'h0;
        flags         = 4'h0;
        flags_pending = 1'b0;
        abort         = 1'b0;
        test_reset();
        test_directed();
        test_abort();
        test_reset_mid_wait();
        test_sweep();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
